frame_buffer_dual: RTL and testbench

Parametrised double-buffered (ping-pong) frame buffer between the sprite/background drawing engines and the VGA output path. Drawing engines write the back bank through a valid/ready port with colour-key transparency. The display reads the front bank with a programmable horizontal scroll offset. Banks swap, and the scroll offset advances, only at frame start, so a frame is never displayed half-drawn.

---
 rtl/frame_buffer_dual.sv | 180 ++++++++++++++++++
 tb/tb_frame_buffer_dual.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_dual.sv
// Ping-pong frame buffer: drawing engines fill the back bank, the display scans the front bank
// with a horizontal scroll. Optional macro FB_CLEAR_ON_SWAP_EN wipes the new back bank after each swap.
module frame_buffer_dual #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int PIX_W      = 5,
    parameter int TRANSP_KEY = 'h15,
    parameter int CLEAR_VAL  = 0,
    localparam int ADDR_W    = $clog2(H_RES * V_RES),
    localparam int XW        = $clog2(H_RES),
    localparam int YW        = $clog2(V_RES)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic             frame_start,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [XW-1:0]    wr_x,
    input  logic [YW-1:0]    wr_y,
    input  logic [PIX_W-1:0] wr_pixel,
    input  logic             swap_req,
    output logic             swap_pending,
    output logic             swap_done,
    input  logic             scroll_en,
    input  logic [XW-1:0]    scroll_step,
    output logic [XW-1:0]    scroll_offset,
    output logic             front_sel,
    output logic [PIX_W-1:0] pixel_out
);
    localparam int DEPTH = H_RES * V_RES;

    typedef enum logic [1:0] {IDLE, ARMED, CLEAR} state_t;

    state_t            state_reg, state_next;
    logic              front_reg;
    logic [XW-1:0]     scroll_reg;
    logic [XW-1:0]     scroll_next;
    logic              swap_done_reg;
    logic              do_swap;

    // ---------------- read path ----------------
    logic [10:0]       xs, xe;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_blank;
    logic              blank_reg;
    logic              rd_sel_reg;
    logic [1:0][PIX_W-1:0] rd_data;

    assign xs       = {1'b0, DrawX} + 11'(scroll_reg);
    assign xe       = (xs >= 11'(H_RES)) ? (xs - 11'(H_RES)) : xs;
    assign rd_addr  = ADDR_W'(xe) + ADDR_W'(DrawY) * ADDR_W'(H_RES);
    assign rd_blank = (DrawX >= 10'(H_RES)) || (DrawY >= 10'(V_RES));

    // Bank select and blanking are delayed to line up with the RAM's registered read.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            blank_reg  <= 1'b1;
            rd_sel_reg <= 1'b0;
        end else begin
            blank_reg  <= rd_blank;
            rd_sel_reg <= front_reg;
        end
    end

    assign pixel_out = blank_reg ? '0 : rd_data[rd_sel_reg];

    // ---------------- write path ----------------
    logic              wr_fire;
    logic              wr_in_range;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [PIX_W-1:0]  bank_wdata;

    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = ({1'b0, wr_x} < (XW + 1)'(H_RES)) && ({1'b0, wr_y} < (YW + 1)'(V_RES));
    assign wr_en       = wr_fire && wr_in_range && (wr_pixel != PIX_W'(TRANSP_KEY));
    assign wr_addr     = ADDR_W'(wr_x) + ADDR_W'(wr_y) * ADDR_W'(H_RES);

`ifdef FB_CLEAR_ON_SWAP_EN
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic              clr_last;
    logic              clearing;
    logic              swap_latch_reg;

    assign clearing   = (state_reg == CLEAR);
    assign clr_last   = (clr_cnt_reg == ADDR_W'(DEPTH - 1));
    assign bank_we    = clearing || wr_en;
    assign bank_waddr = clearing ? clr_cnt_reg : wr_addr;
    assign bank_wdata = clearing ? PIX_W'(CLEAR_VAL) : wr_pixel;

    // A swap request arriving mid-clear is remembered and armed once the clear ends.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clr_cnt_reg    <= '0;
            swap_latch_reg <= 1'b0;
        end else if (clearing) begin
            clr_cnt_reg <= clr_last ? '0 : clr_cnt_reg + 1'b1;
            if (swap_req)
                swap_latch_reg <= 1'b1;
        end else begin
            clr_cnt_reg    <= '0;
            swap_latch_reg <= 1'b0;
        end
    end
`else
    assign bank_we    = wr_en;
    assign bank_waddr = wr_addr;
    assign bank_wdata = wr_pixel;
`endif

    // Writes always target the bank not on display this cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [PIX_W-1:0] mem [DEPTH];
            logic [PIX_W-1:0] rd_q;

            always_ff @(posedge Clk) begin
                if (bank_we && (front_reg != 1'(gi)))
                    mem[bank_waddr] <= bank_wdata;
                rd_q <= mem[rd_addr];
            end

            assign rd_data[gi] = rd_q;
        end
    endgenerate

    // ---------------- swap FSM ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            front_reg     <= 1'b0;
            scroll_reg    <= '0;
            swap_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            swap_done_reg <= do_swap;
            if (do_swap)
                front_reg <= ~front_reg;
            if (frame_start && scroll_en)
                scroll_reg <= scroll_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (swap_req) state_next = ARMED;
`ifdef FB_CLEAR_ON_SWAP_EN
            ARMED: if (frame_start) state_next = CLEAR;
            CLEAR: if (clr_last) state_next = (swap_latch_reg || swap_req) ? ARMED : IDLE;
`else
            ARMED: if (frame_start) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        swap_pending = (state_reg == ARMED);
        do_swap      = (state_reg == ARMED) && frame_start;
`ifdef FB_CLEAR_ON_SWAP_EN
        wr_ready     = (state_reg != CLEAR);
`else
        wr_ready     = 1'b1;
`endif
    end

    logic [XW:0] scroll_sum;
    assign scroll_sum  = {1'b0, scroll_reg} + {1'b0, scroll_step};
    assign scroll_next = (scroll_sum >= (XW + 1)'(H_RES)) ? XW'(scroll_sum - (XW + 1)'(H_RES))
                                                         : XW'(scroll_sum);

    assign swap_done     = swap_done_reg;
    assign front_sel     = front_reg;
    assign scroll_offset = scroll_reg;
endmodule

// File: tb/tb_frame_buffer_dual.sv
// Directed bench for frame_buffer_dual: an 8x4 instance for the main behaviour and a 6x3
// instance whose non-power-of-two size lets out-of-range write coordinates be driven.
module tb_frame_buffer_dual;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] DrawX = 10'd1000;
    logic [9:0] DrawY = 10'd0;
    logic       frame_start = 1'b0;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_x = '0;
    logic [1:0] wr_y = '0;
    logic [4:0] wr_pixel = '0;
    logic       swap_req = 1'b0;
    logic       scroll_en = 1'b0;
    logic [2:0] scroll_step = '0;

    logic       wr_ready, swap_pending, swap_done, front_sel;
    logic [2:0] scroll_offset;
    logic [4:0] pixel_out;
    logic       wr_ready2, swap_pending2, swap_done2, front_sel2;
    logic [2:0] scroll_offset2;
    logic [4:0] pixel_out2;

    int n_checks = 0;
    int n_fail   = 0;

    frame_buffer_dual #(.H_RES(8), .V_RES(4), .PIX_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
        .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
        .scroll_en(scroll_en), .scroll_step(scroll_step), .scroll_offset(scroll_offset),
        .front_sel(front_sel), .pixel_out(pixel_out)
    );

    frame_buffer_dual #(.H_RES(6), .V_RES(3), .PIX_W(5)) dut2 (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
        .swap_req(swap_req), .swap_pending(swap_pending2), .swap_done(swap_done2),
        .scroll_en(scroll_en), .scroll_step(scroll_step), .scroll_offset(scroll_offset2),
        .front_sel(front_sel2), .pixel_out(pixel_out2)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready();
        int cnt = 0;
        while (!(wr_ready && wr_ready2) && cnt < 200) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (!(wr_ready && wr_ready2)) begin
            n_fail++;
            $display("FAIL wait_ready: wr_ready=%b wr_ready2=%b after %0d cycles, required 1", wr_ready, wr_ready2, cnt);
        end
    endtask

    task automatic do_write(input logic [2:0] x, input logic [1:0] y, input logic [4:0] p);
        wait_ready();
        wr_x = x; wr_y = y; wr_pixel = p; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        $display("write (%0d,%0d)=%h", x, y, p);
    endtask

    task automatic read_px(input logic [9:0] x, input logic [9:0] y,
                           output logic [4:0] p, output logic [4:0] p2);
        DrawX = x; DrawY = y;
        tick();
        p = pixel_out; p2 = pixel_out2;
        DrawX = 10'd1000;
        $display("read (%0d,%0d) -> %h / %h", x, y, p, p2);
    endtask

    task automatic pulse(input logic sr, input logic fs);
        swap_req = sr; frame_start = fs;
        tick();
        swap_req = 1'b0; frame_start = 1'b0;
        $display("pulse swap_req=%b frame_start=%b -> front_sel=%b swap_done=%b pending=%b offset=%0d",
                 sr, fs, front_sel, swap_done, swap_pending, scroll_offset);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        $display("reset released");
        n_checks++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL reset_front got %b want 0", front_sel); end
        n_checks++; if (scroll_offset !== 3'd0) begin n_fail++; $display("FAIL reset_scroll got %0d want 0", scroll_offset); end
        n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", swap_pending); end
        n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", swap_done); end
        n_checks++; if (pixel_out !== 5'h00) begin n_fail++; $display("FAIL reset_pixel got %h want 00", pixel_out); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    endtask

    task automatic test_basic();
        logic [4:0] p, p2;
        do_write(3'd3, 2'd1, 5'h07);
        pulse(1'b1, 1'b0);
        n_checks++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL basic_pending got %b want 1", swap_pending); end
        n_checks++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL basic_front_early got %b want 0", front_sel); end
        pulse(1'b0, 1'b1);
        n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", swap_done); end
        n_checks++; if (front_sel !== 1'b1) begin n_fail++; $display("FAIL basic_front got %b want 1", front_sel); end
        n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL basic_pending_clr got %b want 0", swap_pending); end
        tick();
        n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", swap_done); end
        read_px(10'd3, 10'd1, p, p2);
        n_checks++; if (p !== 5'h07) begin n_fail++; $display("FAIL basic_pixel got %h want 07", p); end
    endtask

    task automatic test_transparency();
        logic [4:0] p, p2;
        do_write(3'd2, 2'd2, 5'h09);
        do_write(3'd3, 2'd2, 5'h0B);
        do_write(3'd2, 2'd2, 5'h15);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        n_checks++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL transp_front got %b want 0", front_sel); end
        read_px(10'd2, 10'd2, p, p2);
        n_checks++; if (p !== 5'h09) begin n_fail++; $display("FAIL transp_key got %h want 09", p); end
        read_px(10'd3, 10'd2, p, p2);
        n_checks++; if (p !== 5'h0B) begin n_fail++; $display("FAIL transp_neighbour got %h want 0B", p); end
    endtask

    task automatic test_scroll();
        logic [4:0] p, p2;
        scroll_en = 1'b1; scroll_step = 3'd3;
        pulse(1'b0, 1'b1);
        n_checks++; if (scroll_offset !== 3'd3) begin n_fail++; $display("FAIL scroll_1 got %0d want 3", scroll_offset); end
        n_checks++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL scroll_no_swap got %b want 0", front_sel); end
        pulse(1'b0, 1'b1);
        n_checks++; if (scroll_offset !== 3'd6) begin n_fail++; $display("FAIL scroll_2 got %0d want 6", scroll_offset); end
        n_checks++; if (scroll_offset2 !== 3'd0) begin n_fail++; $display("FAIL scroll_wrap_6 got %0d want 0", scroll_offset2); end
        read_px(10'd5, 10'd2, p, p2);
        n_checks++; if (p !== 5'h0B) begin n_fail++; $display("FAIL scroll_read_x5 got %h want 0B", p); end
        read_px(10'd4, 10'd2, p, p2);
        n_checks++; if (p !== 5'h09) begin n_fail++; $display("FAIL scroll_read_x4 got %h want 09", p); end
        pulse(1'b0, 1'b1);
        n_checks++; if (scroll_offset !== 3'd1) begin n_fail++; $display("FAIL scroll_3 got %0d want 1", scroll_offset); end
        scroll_en = 1'b0;
        pulse(1'b0, 1'b1);
        n_checks++; if (scroll_offset !== 3'd1) begin n_fail++; $display("FAIL scroll_hold got %0d want 1", scroll_offset); end
    endtask

    task automatic test_swap_same_cycle();
        wait_ready();
        pulse(1'b1, 1'b1);
        n_checks++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL same_pending got %b want 1", swap_pending); end
        n_checks++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL same_front got %b want 0", front_sel); end
        n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL same_done got %b want 0", swap_done); end
        pulse(1'b1, 1'b0);
        n_checks++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL same_absorb got %b want 1", swap_pending); end
        pulse(1'b0, 1'b1);
        n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL same_done2 got %b want 1", swap_done); end
        n_checks++; if (front_sel !== 1'b1) begin n_fail++; $display("FAIL same_front2 got %b want 1", front_sel); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] p, p2;
        wait_ready();
        pulse(1'b1, 1'b0);
        wr_x = 3'd1; wr_y = 2'd1; wr_pixel = 5'h0C; wr_valid = 1'b1;
        pulse(1'b0, 1'b1);
        wr_valid = 1'b0;
        $display("write (1,1)=0c on swap cycle");
        n_checks++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL b2b_front got %b want 0", front_sel); end
        read_px(10'd0, 10'd1, p, p2);
        n_checks++; if (p !== 5'h0C) begin n_fail++; $display("FAIL b2b_pixel got %h want 0C", p); end
    endtask

    task automatic test_out_of_range();
        logic [4:0] p, p2;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        $display("reset pulse");
        do_write(3'd0, 2'd1, 5'h0A);
        wr_x = 3'd6; wr_y = 2'd0; wr_pixel = 5'h0D; wr_valid = 1'b1;
        #1;
        n_checks++; if (wr_ready2 !== 1'b1) begin n_fail++; $display("FAIL oor_ready_x got %b want 1", wr_ready2); end
        tick();
        wr_x = 3'd7; wr_y = 2'd3; wr_pixel = 5'h0E;
        #1;
        n_checks++; if (wr_ready2 !== 1'b1) begin n_fail++; $display("FAIL oor_ready_y got %b want 1", wr_ready2); end
        tick();
        wr_valid = 1'b0;
        $display("write (6,0)=0d and (7,3)=0e");
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        read_px(10'd0, 10'd1, p, p2);
        n_checks++; if (p !== 5'h0A) begin n_fail++; $display("FAIL oor_keep got %h want 0A", p); end
        n_checks++; if (p2 !== 5'h0A) begin n_fail++; $display("FAIL oor_discard_x got %h want 0A", p2); end
        read_px(10'd6, 10'd0, p, p2);
        n_checks++; if (p !== 5'h0D) begin n_fail++; $display("FAIL oor_col6 got %h want 0D", p); end
        n_checks++; if (p2 !== 5'h00) begin n_fail++; $display("FAIL oor_blank6 got %h want 00", p2); end
        read_px(10'd7, 10'd3, p, p2);
        n_checks++; if (p !== 5'h0E) begin n_fail++; $display("FAIL oor_corner got %h want 0E", p); end
        read_px(10'd8, 10'd0, p, p2);
        n_checks++; if (p !== 5'h00) begin n_fail++; $display("FAIL oor_blank_x got %h want 00", p); end
        read_px(10'd0, 10'd4, p, p2);
        n_checks++; if (p !== 5'h00) begin n_fail++; $display("FAIL oor_blank_y got %h want 00", p); end
    endtask

`ifdef FB_CLEAR_ON_SWAP_EN
    task automatic test_clear();
        logic [4:0] p, p2;
        int busy = 0;
        wait_ready();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        while (!wr_ready && busy < 100) begin
            busy++;
            tick();
        end
        n_checks++; if (busy != 32) begin n_fail++; $display("FAIL clear_len got %0d want 32", busy); end
        wait_ready();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        read_px(10'd0, 10'd1, p, p2);
        n_checks++; if (p !== 5'h00) begin n_fail++; $display("FAIL clear_val01 got %h want 00", p); end
        read_px(10'd7, 10'd3, p, p2);
        n_checks++; if (p !== 5'h00) begin n_fail++; $display("FAIL clear_val73 got %h want 00", p); end
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL clear_busy got %b want 0", wr_ready); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        $display("reset during clear");
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL clear_abort_ready got %b want 1", wr_ready); end
        n_checks++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL clear_abort_front got %b want 0", front_sel); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_transparency();
        test_scroll();
        test_swap_same_cycle();
        test_back_to_back();
        test_out_of_range();
`ifdef FB_CLEAR_ON_SWAP_EN
        test_clear();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
